// File: rtl/cache_miss_controller_pkg.sv
// Shared cache geometry and miss-sequencer state encoding.
// Imported by the miss controller and by anything sized against the line array.
package cache_miss_controller_pkg;

    localparam int unsigned CACHE_SET_SIZE    = 4;
    localparam int unsigned CACHE_LINE_WORDS  = 4;
    localparam int unsigned CACHE_TAG_WIDTH   = 20;
    localparam int unsigned CACHE_INDEX_WIDTH = 8;
    localparam int unsigned CACHE_ADDR_WIDTH  = 32;
    localparam int unsigned CACHE_DATA_WIDTH  = 32;
    localparam int unsigned CACHE_BYTE_OFF    = 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        COMMIT
    } miss_state_t;

endpackage

// File: rtl/cache_miss_controller.sv
// Per-set miss sequencer: hit/miss reporting, dirty-victim writeback,
// word-by-word refill from memory and final tag/valid commit.
module cache_miss_controller
    import cache_miss_controller_pkg::*;
#(
    parameter int unsigned SET_SIZE    = CACHE_SET_SIZE,
    parameter int unsigned LINE_WORDS  = CACHE_LINE_WORDS,
    parameter int unsigned TAG_WIDTH   = CACHE_TAG_WIDTH,
    parameter int unsigned INDEX_WIDTH = CACHE_INDEX_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    input  logic [CACHE_ADDR_WIDTH-1:0]   req_addr_i,
    output logic                          cpu_ready_o,
    input  logic [SET_SIZE-1:0]           hit_line_i,
    input  logic [SET_SIZE-1:0]           victim_line_i,
    input  logic                          victim_dirty_i,
    input  logic [TAG_WIDTH-1:0]          victim_tag_i,
    input  logic [CACHE_DATA_WIDTH-1:0]   victim_rdata_i,
    output logic                          replace_en_o,
    output logic [SET_SIZE-1:0]           line_sel_o,
    output logic [$clog2(LINE_WORDS)-1:0] line_word_o,
    output logic                          line_we_o,
    output logic                          line_commit_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [CACHE_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [CACHE_DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                          mem_ready_i,
    input  logic [CACHE_DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned WORD_W  = $clog2(LINE_WORDS);
    localparam int unsigned LOW_W   = WORD_W + CACHE_BYTE_OFF;
    localparam int unsigned LAST_WD = LINE_WORDS - 1;

    miss_state_t            state_q, state_d;
    logic [WORD_W-1:0]      cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]   req_tag_q, victim_tag_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [SET_SIZE-1:0]    victim_q;
    logic                   latch_en;
    logic                   last_word;
    logic [WORD_W-1:0]      cnt_inc;

    // Word/byte offset of the CPU address never reaches the memory side.
    logic [LOW_W-1:0]            unused_addr_low;
    logic [CACHE_DATA_WIDTH-1:0] unused_rdata;
    assign unused_addr_low = req_addr_i[LOW_W-1:0];
    assign unused_rdata    = mem_rdata_i;

    assign last_word = (cnt_q == WORD_W'(LAST_WD));
    assign cnt_inc   = last_word ? '0 : cnt_q + WORD_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_tag_q    <= '0;
            index_q      <= '0;
            victim_q     <= '0;
            victim_tag_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                req_tag_q    <= req_addr_i[CACHE_ADDR_WIDTH-1 -: TAG_WIDTH];
                index_q      <= req_addr_i[LOW_W +: INDEX_WIDTH];
                victim_q     <= victim_line_i;
                victim_tag_q <= victim_tag_i;
            end
        end
    end

    // Next state and output decode; everything is held at 0 while reset is asserted.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        latch_en      = 1'b0;
        cpu_ready_o   = 1'b0;
        replace_en_o  = 1'b0;
        line_sel_o    = '0;
        line_word_o   = '0;
        line_we_o     = 1'b0;
        line_commit_o = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;

        if (!rst_i) begin
            line_word_o = cnt_q;
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        if (|hit_line_i) begin
                            cpu_ready_o  = 1'b1;
                            replace_en_o = 1'b1;
                        end else begin
                            latch_en = 1'b1;
                            cnt_d    = '0;
                            state_d  = victim_dirty_i ? WRITEBACK : REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    line_sel_o  = victim_q;
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = CACHE_ADDR_WIDTH'({victim_tag_q, index_q, cnt_q, 2'b00});
                    mem_wdata_o = victim_rdata_i;
                    if (mem_ready_i) begin
                        cnt_d = cnt_inc;
                        if (last_word) state_d = REFILL;
                    end
                end
                REFILL: begin
                    line_sel_o = victim_q;
                    mem_req_o  = 1'b1;
                    mem_addr_o = CACHE_ADDR_WIDTH'({req_tag_q, index_q, cnt_q, 2'b00});
                    line_we_o  = mem_ready_i;
                    if (mem_ready_i) begin
                        cnt_d = cnt_inc;
                        if (last_word) state_d = COMMIT;
                    end
                end
                COMMIT: begin
                    line_sel_o    = victim_q;
                    line_commit_o = 1'b1;
                    replace_en_o  = 1'b1;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_controller.sv
// Self-checking bench for cache_miss_controller: vector table, directed miss
// sequences and randomized traffic against a transaction-queue reference model.
module tb_cache_miss_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        cpu_ready;
    logic [3:0]  hit_line;
    logic [3:0]  victim_line;
    logic        victim_dirty;
    logic [19:0] victim_tag;
    logic [31:0] victim_rdata;
    logic        replace_en;
    logic [3:0]  line_sel;
    logic [1:0]  line_word;
    logic        line_we;
    logic        line_commit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    cache_miss_controller dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_addr_i     (req_addr),
        .cpu_ready_o    (cpu_ready),
        .hit_line_i     (hit_line),
        .victim_line_i  (victim_line),
        .victim_dirty_i (victim_dirty),
        .victim_tag_i   (victim_tag),
        .victim_rdata_i (victim_rdata),
        .replace_en_o   (replace_en),
        .line_sel_o     (line_sel),
        .line_word_o    (line_word),
        .line_we_o      (line_we),
        .line_commit_o  (line_commit),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_ready_i    (mem_ready),
        .mem_rdata_i    (mem_rdata)
    );

    typedef struct packed {
        logic        cpu_ready;
        logic        replace_en;
        logic [3:0]  line_sel;
        logic [1:0]  line_word;
        logic        line_we;
        logic        line_commit;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } outs_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  word;
    } op_t;

    typedef struct packed {
        logic        rv;
        logic [31:0] addr;
        logic [3:0]  hit;
        logic        exp_ready;
        logic        exp_repl;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: a miss becomes a list of memory word operations plus a commit.
    op_t        ops[$];
    logic       commit_pend = 1'b0;
    logic [3:0] m_victim    = '0;

    logic [31:0] s_ready, s_repl, s_addr, s_line_we, s_commit, s_memreq, s_memwe, s_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        outs_t e, a;
        e = '0;
        if (!rst) begin
            if (ops.size() > 0) begin
                e.mem_req   = 1'b1;
                e.mem_we    = ops[0].we;
                e.mem_addr  = ops[0].addr;
                e.line_word = ops[0].word;
                e.line_sel  = m_victim;
                e.line_we   = !ops[0].we && mem_ready;
                e.mem_wdata = ops[0].we ? victim_rdata : 32'h0;
            end else if (commit_pend) begin
                e.line_commit = 1'b1;
                e.replace_en  = 1'b1;
                e.line_sel    = m_victim;
            end else if (req_valid && hit_line != '0) begin
                e.cpu_ready  = 1'b1;
                e.replace_en = 1'b1;
            end
        end
        a = '{cpu_ready, replace_en, line_sel, line_word, line_we, line_commit,
              mem_req, mem_we, mem_addr, mem_wdata};
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL model cyc=%0d actual=%h required=%h", cyc, a, e);
        end
        if (rst) begin
            ops.delete();
            commit_pend = 1'b0;
        end else if (ops.size() > 0) begin
            if (mem_ready) void'(ops.pop_front());
        end else if (commit_pend) begin
            commit_pend = 1'b0;
        end else if (req_valid && hit_line == '0) begin
            m_victim = victim_line;
            if (victim_dirty)
                for (int w = 0; w < 4; w++)
                    ops.push_back('{1'b1, {victim_tag, req_addr[11:4], 2'(w), 2'b00}, 2'(w)});
            for (int w = 0; w < 4; w++)
                ops.push_back('{1'b0, {req_addr[31:12], req_addr[11:4], 2'(w), 2'b00}, 2'(w)});
            commit_pend = 1'b1;
        end
    endtask

    // One cycle: drive after the edge, check at the falling edge, advance.
    task automatic step(input logic rv, input logic [31:0] a, input logic [3:0] hit, input logic mr);
        req_valid    = rv;
        req_addr     = a;
        hit_line     = hit;
        mem_ready    = mr;
        victim_rdata = $urandom;
        mem_rdata    = $urandom;
        @(negedge clk);
        model_check();
        s_ready   = 32'(cpu_ready);
        s_repl    = 32'(replace_en);
        s_addr    = mem_addr;
        s_line_we = 32'(line_we);
        s_commit  = 32'(line_commit);
        s_memreq  = 32'(mem_req);
        s_memwe   = 32'(mem_we);
        s_word    = 32'(line_word);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1'b0, 32'h0000_1040, 4'b0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_1040, 4'b0010, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 32'h0000_1040, 4'b0010, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_2000, 4'b0001, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 4'b1000, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h1234_5678, 4'b0100, 1'b1, 1'b1};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; hit_line = '0;
        victim_line = '0; victim_dirty = 1'b0; victim_tag = '0;
        victim_rdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        @(posedge clk); #1;
        step(1'b0, 32'h0, 4'b0, 1'b1);
        step(1'b0, 32'h0, 4'b0, 1'b1);
        rst = 1'b0;
        step(1'b0, 32'h0, 4'b0, 1'b1);
        check("reset_memreq", s_memreq, 32'h0);
        check("reset_ready", s_ready, 32'h0);

        for (int i = 0; i < 6; i++) begin
            step(vecs[i].rv, vecs[i].addr, vecs[i].hit, 1'($urandom));
            check("vec_ready", s_ready, 32'(vecs[i].exp_ready));
            check("vec_repl", s_repl, 32'(vecs[i].exp_repl));
            check("vec_memreq", s_memreq, 32'h0);
        end

        // Clean miss, memory always ready
        victim_line = 4'b0100; victim_dirty = 1'b0; victim_tag = 20'h12345;
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        check("clean_miss_ready", s_ready, 32'h0);
        check("clean_miss_memreq", s_memreq, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 32'h1040, 4'b0, 1'b1);
            check("clean_rd_addr", s_addr, 32'h1040 + 32'(4 * k));
            check("clean_line_we", s_line_we, 32'h1);
            check("clean_mem_we", s_memwe, 32'h0);
        end
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        check("clean_commit", s_commit, 32'h1);
        step(1'b1, 32'h1040, 4'b0100, 1'b1);
        check("clean_rehit", s_ready, 32'h1);

        // Dirty miss: writeback to the victim's address, then refill
        victim_line = 4'b0001; victim_dirty = 1'b1; victim_tag = 20'hABCDE;
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 32'h1040, 4'b0, 1'b1);
            check("dirty_wb_addr", s_addr, 32'hABCD_E040 + 32'(4 * k));
            check("dirty_wb_we", s_memwe, 32'h1);
            check("dirty_wb_line_we", s_line_we, 32'h0);
        end
        victim_dirty = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 32'h1040, 4'b0, 1'b1);
            check("dirty_rd_addr", s_addr, 32'h1040 + 32'(4 * k));
            check("dirty_rd_we", s_memwe, 32'h0);
        end
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        check("dirty_commit", s_commit, 32'h1);
        step(1'b1, 32'h1040, 4'b0001, 1'b1);
        check("dirty_rehit", s_ready, 32'h1);

        // Stalled memory: three idle cycles per word
        victim_line = 4'b1000; victim_dirty = 1'b0;
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            for (int s = 0; s < 4; s++) begin
                step(1'b1, 32'h1040, 4'b0, s == 3);
                check("stall_addr", s_addr, 32'h1040 + 32'(4 * k));
                check("stall_req", s_memreq, 32'h1);
                check("stall_word", s_word, 32'(k));
                check("stall_line_we", s_line_we, 32'(s == 3));
            end
        step(1'b1, 32'h1040, 4'b0, 1'b0);
        check("stall_commit", s_commit, 32'h1);
        step(1'b1, 32'h1040, 4'b1000, 1'b0);

        // Reset in the middle of a refill, then restart from word 0
        victim_line = 4'b0010; victim_dirty = 1'b0;
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        rst = 1'b1;
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        rst = 1'b0;
        step(1'b0, 32'h1040, 4'b0, 1'b1);
        check("rst_mid_memreq", s_memreq, 32'h0);
        check("rst_mid_commit", s_commit, 32'h0);
        check("rst_mid_word", s_word, 32'h0);
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        check("restart_addr", s_addr, 32'h1040);
        check("restart_word", s_word, 32'h0);
        for (int k = 0; k < 4; k++) step(1'b1, 32'h1040, 4'b0, 1'b1);
        step(1'b1, 32'h1040, 4'b0010, 1'b1);

        // Address and request change mid-miss; latched line still refilled
        victim_line = 4'b0100;
        step(1'b1, 32'h1040, 4'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'($urandom), 32'h2000, 4'($urandom), 1'b1);
            check("addrchg_addr", s_addr, 32'h1040 + 32'(4 * k));
        end
        step(1'b0, 32'h2000, 4'b1111, 1'b1);
        check("addrchg_commit", s_commit, 32'h1);
        step(1'b1, 32'h1040, 4'b0100, 1'b1);
        check("addrchg_rehit", s_ready, 32'h1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic [3:0] h;
            h = ($urandom_range(0, 1) == 1) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'b0000;
            victim_line  = 4'(4'b0001 << $urandom_range(0, 3));
            victim_dirty = 1'($urandom);
            victim_tag   = 20'($urandom);
            rst          = ($urandom_range(0, 63) == 0);
            step(1'($urandom), $urandom, h, $urandom_range(0, 9) < 6);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
